// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between execute stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, dividend, divisor, flush,
        output busy, done, result
    );

endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.
module div_unit
    import div_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN+1:0]  shifted, trial;
    logic [XLEN:0]    step_rem;
    logic [XLEN-1:0]  step_quo, quo_fix, rem_fix;

    div_op_t          op;
    logic             is_signed, op_rem, a_neg, b_neg;
    logic [XLEN-1:0]  a_abs, b_abs;

    // One step; the partial remainder is always below the divisor,
    // so the extra top bit only ever carries the trial sign.
    always_comb begin : trial_sub
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {2'b00, dvs_q};
        if (!trial[XLEN+1]) begin
            step_rem = trial[XLEN:0];
            step_quo = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem = shifted[XLEN:0];
            step_quo = {quo_q[XLEN-2:0], 1'b0};
        end
        quo_fix = q_neg_q ? -step_quo : step_quo;
        rem_fix = r_neg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    end

    always_comb begin : next_state
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        op        = div_op_t'(bus.funct3);
        is_signed = (op == OP_DIV) || (op == OP_REM);
        op_rem    = (op == OP_REM) || (op == OP_REMU);
        a_neg     = is_signed && bus.dividend[XLEN-1];
        b_neg     = is_signed && bus.divisor[XLEN-1];
        a_abs     = a_neg ? -bus.dividend : bus.dividend;
        b_abs     = b_neg ? -bus.divisor : bus.divisor;

        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.funct3[2]) begin
                    if (bus.divisor == '0) begin
                        result_d = op_rem ? bus.dividend : '1;
                        state_d  = DONE;
                    end else if (is_signed
                                 && bus.dividend == OVF_DIVIDEND
                                 && bus.divisor == '1) begin
                        result_d = op_rem ? '0 : OVF_DIVIDEND;
                        state_d  = DONE;
                    end else begin
                        rem_d    = '0;
                        quo_d    = a_abs;
                        dvs_d    = b_abs;
                        cnt_d    = '0;
                        is_rem_d = op_rem;
                        q_neg_d  = a_neg ^ b_neg;
                        r_neg_d  = a_neg;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                // Result lands with the edge that raises done.
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    div_unit_if bus();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(logic [2:0] f3,
                                            logic [31:0] a,
                                            logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic sgn;
        logic remop;
        sa    = a;
        sb    = b;
        sgn   = !f3[0];
        remop = f3[1];
        if (b == 32'd0)
            return remop ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return remop ? 32'd0 : 32'h8000_0000;
        if (sgn) begin
            sr = remop ? (sa % sb) : (sa / sb);
            return sr;
        end
        return remop ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(logic [2:0] f3,
                                   logic [31:0] a,
                                   logic [31:0] b);
        if (b == 32'd0)
            return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    // m_cnt: busy cycles remaining including the current one.
    int          m_cnt;
    logic [31:0] m_pend;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_res  = 32'd0;
            m_pend = 32'd0;
        end else begin
            if (bus.flush)
                m_cnt = 0;
            else if (m_cnt > 0)
                m_cnt = m_cnt - 1;
            else if (bus.start && bus.funct3[2]) begin
                m_pend = ref_div(bus.funct3, bus.dividend, bus.divisor);
                m_cnt  = ref_lat(bus.funct3, bus.dividend, bus.divisor);
            end
            if (m_cnt == 1)
                m_res = m_pend;
        end
    end

    always @(posedge clk) begin
        #2;
        check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_cnt > 0});
        check("cyc_done", {31'd0, bus.done}, {31'd0, m_cnt == 1});
        check("cyc_result", bus.result, m_res);
    end

    task automatic run_op(string name, logic [2:0] f3, logic [31:0] a,
                          logic [31:0] b, logic [31:0] exp, int lat);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.dividend = a;
        bus.divisor  = b;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.done)
                seen = 1;
        end
        check({name, " latency"}, cyc, lat);
        check({name, " result"}, bus.result, exp);
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.funct3   = 3'b000;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        bus.flush    = 1'b0;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("rem -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu 5%0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("div -100/7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        run_op("rem -100%7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        run_op("div 100/-7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("rem 100%-7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
        run_op("divu max/1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("divu big", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("remu 7%100", 3'b111, 32'd7, 32'd100, 32'd7, 33);
        run_op("divu ovf unsigned", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = 3'b000;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("f3 000 ignored", {31'd0, bus.busy}, 32'd0);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'b101;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush+start busy", {31'd0, bus.busy}, 32'd0);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = 3'b101;
        bus.dividend = 32'hFFFF_0000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        check("flush done", {31'd0, bus.done}, 32'd0);
        check("flush result held", bus.result, 32'd0);
        run_op("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = 3'b100;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, bus.busy}, 32'd0);
        check("async rst done", {31'd0, bus.done}, 32'd0);
        check("async rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("remu 100%7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sequenced by its own state machine. Sits beside the single-cycle ALU in the execute stage. The pipeline launches it when the decoder reports an M-extension operation with funct3[2]=1, and holds execute stalled until `done`. Handles RISC-V special cases (divide-by-zero, signed overflow) without iterating.

## Interface
- `XLEN`, 32, operand/result width; the iteration count equals `XLEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `funct3`  in  3  operation: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
- `dividend`  in  XLEN  rs1 value, sampled with `start`.
- `divisor`  in  XLEN  rs2 value, sampled with `start`.
- `flush`  in  1  synchronous kill of any operation in flight.
- `busy`  out  1  registered; high in every state except IDLE.
- `done`  out  1  registered; one-cycle pulse, `result` valid in that cycle.
- `result`  out  XLEN  quotient or remainder; holds its value until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.
- IDLE, `start`=1, `funct3[2]`=0: request ignored; state stays IDLE.
- IDLE, `start`=1, `funct3[2]`=1: latch op, operand signs and absolute values (signed ops only; unsigned ops use raw values).
  - divisor==0: quotient result = all ones; remainder result = dividend. Next state DONE.
  - Signed op with dividend==0x8000_0000 and divisor==0xFFFF_FFFF: DIV result 0x8000_0000; REM result 0. Next state DONE.
  - Otherwise: clear the partial remainder, set the counter to 0, next state CALC.
- CALC: restoring radix-2 step per cycle.
  - Shift {rem, quo} left 1.
  - Trial subtract the divisor from the XLEN+1-bit remainder.
  - If the trial is non-negative, keep it and set the quotient LSB.
  - After step XLEN-1 (counter == XLEN-1), go to DONE.
- DONE:
  - `done`=1, and `result` is written in this same cycle.
  - Signed correction: the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - Special-case results bypass correction.
  - Next state IDLE unconditionally; `start` is ignored in DONE.
- `flush`=1 in any state: next state IDLE, `done` stays 0, `result` unchanged.
- `flush` and `start` in the same cycle: `flush` wins and nothing launches.
- Asynchronous reset mid-operation: all outputs return to reset values immediately; no `done` is produced.
- Requester rule: `start` must fall in the cycle after `done`. A still-high `start` in IDLE is a new launch.

## Timing
- Normal op: `start` sampled at edge N. `busy` is high from N+1 through N+XLEN+1. `done` is high in cycle N+XLEN+1 (33 cycles for XLEN=32). `busy` is 0 at N+XLEN+2.
- Special case: `done` and `busy` are high in cycle N+1 only (latency 1).
- Throughput: one operation per XLEN+2 cycles. Back-to-back operations need one IDLE cycle between them.
- No combinational path from any input to any output.

## Structure
- Shared package:
  - `div_op_t` enum (DIV, DIVU, REM, REMU, encoded as funct3).
  - `div_state_t` enum (IDLE, CALC, DONE).
  - The overflow constant, derived from `XLEN`.
- Single module. The per-cycle trial subtract is an inline always_comb, not a sub-module.
- Counter width is $clog2(XLEN). The partial remainder register is XLEN+1 bits.

## Test plan
- DIVU 100 / 7, `start` at edge N: `busy` high N+1..N+33; `done` at N+33 with `result`=14; `busy`=0 at N+34.
- REM 0xFFFF_FFF9 (-7) % 2: `result`=0xFFFF_FFFF. DIV -7 / 2: `result`=0xFFFF_FFFD (-3).
- DIV 5 / 0: `done` at N+1 with 0xFFFF_FFFF. REMU 5 % 0: `result`=5, latency 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF: `result`=0x8000_0000. REM of the same operands: `result`=0. Both at latency 1.
- Flush at cycle N+10 of a DIVU: no `done`, `busy`=0 next cycle. A new DIVU 9 / 3 started after that returns 3 at the normal latency.
- Edge cases: `rst_n` low at N+5 gives immediate `busy`=0, `done`=0, `result`=0. `start` with funct3=3'b000 is ignored (`busy` stays 0). `flush`+`start` in the same cycle launches nothing.
